mem_requester: RTL and testbench

- CPU-side initiator for the RAM1/UART memory controller.
- Arbitrates instruction-fetch (IF) and MEM-stage data requests, and issues one access at a time over the need_to_work/mem_rd/mem_wr/mem_addr/mem_value interface.
- Tracks completion through the controller's level-type work_done, returns read data, and drives the pipeline stall.
- Serves the UART status register locally, using the controller's RX queue pointers, without issuing an access.

---
 rtl/mem_requester.sv | 171 +++++++++++++++++
 tb/tb_mem_requester.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// Arbitrates instruction-fetch and MEM-stage data requests and issues one access at a time
// to the RAM1/UART memory controller. The UART status register is answered locally.
module mem_requester #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned TIMEOUT        = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_valid,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        stall,
  output logic        err,
  output logic        need_to_work,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_value,
  input  logic        work_done,
  input  logic [15:0] result,
  input  logic [3:0]  front,
  input  logic [3:0]  tail
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              sel_data_q, sel_data_d;
  logic              ntw_q, ntw_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_value_q, mem_value_d;
  logic [15:0]       if_data_q, if_data_d;
  logic [15:0]       d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic data_req;
  logic stat_rd;
  logic timeout_hit;

  assign data_req    = d_rd | d_wr;
  // If both addresses are configured equal, the data port wins and the access is forwarded.
  assign stat_rd     = d_rd && !d_wr && (d_addr == UART_STAT_ADDR) &&
                       (UART_STAT_ADDR != UART_DATA_ADDR);
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    sel_data_d  = sel_data_q;
    ntw_d       = ntw_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_value_d = mem_value_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    cnt_d       = '0;

    unique case (state_q)
      StIdle: begin
        if (data_req) begin
          sel_data_d = 1'b1;
          if (stat_rd) begin
            d_rdata_d = {14'b0, (front != tail), 1'b1};
            state_d   = StResp;
          end else begin
            mem_addr_d  = d_addr;
            mem_value_d = d_wdata;
            mem_wr_d    = d_wr;
            mem_rd_d    = !d_wr;
            ntw_d       = 1'b1;
            state_d     = StIssue;
          end
        end else if (if_req) begin
          sel_data_d = 1'b0;
          mem_addr_d = if_addr;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
          ntw_d      = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue, StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == StWait && work_done) begin
          if (sel_data_q && mem_rd_q) d_rdata_d = result;
          else if (!sel_data_q)       if_data_d = result;
          state_d = StResp;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          ntw_d   = 1'b0;
          if (sel_data_q) d_rdata_d = 16'hFFFF;
          else            if_data_d = 16'hFFFF;
          state_d = StResp;
        end else if (state_q == StIssue && !work_done) begin
          // work_done still high means the controller is draining an RX byte first.
          ntw_d   = 1'b0;
          state_d = StWait;
        end
      end
      StResp: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sel_data_q  <= 1'b0;
      ntw_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_value_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_data_q  <= sel_data_d;
      ntw_q       <= ntw_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_value_q <= mem_value_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    stall = 1'b1;
    unique case (state_q)
      StIdle:  stall = data_req | if_req;
      StResp:  stall = sel_data_q ? if_req : data_req;
      default: stall = 1'b1;
    endcase
  end

  assign if_valid     = (state_q == StResp) && !sel_data_q;
  assign d_valid      = (state_q == StResp) && sel_data_q;
  assign need_to_work = ntw_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_value    = mem_value_q;
  assign if_data      = if_data_q;
  assign d_rdata      = d_rdata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester; work_done/result are driven by hand per scenario.
module tb_mem_requester;

  logic        clk, rst;
  logic        if_req, d_rd, d_wr, work_done;
  logic [15:0] if_addr, d_addr, d_wdata, result;
  logic [3:0]  front, tail;
  logic [15:0] if_data, d_rdata, mem_addr, mem_value;
  logic        if_valid, d_valid, stall, err, need_to_work, mem_rd, mem_wr;

  int vectors = 0;
  int miscompares = 0;

  mem_requester dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall), .err(err),
    .need_to_work(need_to_work), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_value(mem_value),
    .work_done(work_done), .result(result), .front(front), .tail(tail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; if_req = 0; d_rd = 0; d_wr = 0; work_done = 1;
    if_addr = 0; d_addr = 0; d_wdata = 0; result = 0; front = 0; tail = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr, mem_value} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got %h exp 0", {need_to_work, mem_rd, mem_wr, mem_addr, mem_value});
    end
    vectors++;
    if ({if_data, d_rdata, if_valid, d_valid, err, stall} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got %h exp 0", {if_data, d_rdata, if_valid, d_valid, err, stall});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 16'h0040;
    #1 vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall0: got %b exp 1", stall); end
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b1, 1'b0, 16'h0040}) begin
      miscompares++;
      $display("FAIL fetch_issue: got %h exp %h", {need_to_work, mem_rd, mem_wr, mem_addr},
               {1'b1, 1'b1, 1'b0, 16'h0040});
    end
    work_done = 0;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, stall} !== 3'b011) begin
      miscompares++; $display("FAIL fetch_wait: got %b exp 011", {need_to_work, mem_rd, stall});
    end
    work_done = 1; result = 16'h0800;
    @(negedge clk);
    vectors++;
    if ({if_valid, d_valid, stall, if_data} !== {3'b100, 16'h0800}) begin
      miscompares++;
      $display("FAIL fetch_resp: got %h exp %h", {if_valid, d_valid, stall, if_data}, {3'b100, 16'h0800});
    end
    if_req = 0;
    @(negedge clk);
    vectors++;
    if ({if_valid, mem_rd, if_data} !== {2'b00, 16'h0800}) begin
      miscompares++; $display("FAIL fetch_idle: got %h exp 00800", {if_valid, mem_rd, if_data});
    end
  endtask

  task automatic test_store();
    d_wr = 1; d_addr = 16'h8000; d_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr, mem_value} !== {3'b101, 16'h8000, 16'h1234}) begin
      miscompares++;
      $display("FAIL store_issue: got %h exp %h", {need_to_work, mem_rd, mem_wr, mem_addr, mem_value},
               {3'b101, 16'h8000, 16'h1234});
    end
    work_done = 0;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr, mem_value} !== {3'b001, 16'h8000, 16'h1234}) begin
      miscompares++;
      $display("FAIL store_wait: got %h exp %h", {need_to_work, mem_rd, mem_wr, mem_addr, mem_value},
               {3'b001, 16'h8000, 16'h1234});
    end
    work_done = 1; result = 16'hDEAD;
    @(negedge clk);
    vectors++;
    if ({d_valid, if_valid, mem_rd, stall, d_rdata} !== {4'b1000, 16'h0000}) begin
      miscompares++;
      $display("FAIL store_resp: got %h exp %h", {d_valid, if_valid, mem_rd, stall, d_rdata}, 20'h80000);
    end
    d_wr = 0;
    @(negedge clk);
    vectors++;
    if ({d_valid, mem_rd, mem_wr} !== 3'b000) begin
      miscompares++; $display("FAIL store_idle: got %b exp 000", {d_valid, mem_rd, mem_wr});
    end
  endtask

  task automatic test_both();
    d_rd = 1; d_addr = 16'h9000; if_req = 1; if_addr = 16'h0050;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr} !== {3'b110, 16'h9000}) begin
      miscompares++;
      $display("FAIL both_data_issue: got %h exp %h", {need_to_work, mem_rd, mem_wr, mem_addr},
               {3'b110, 16'h9000});
    end
    work_done = 0;
    @(negedge clk);
    work_done = 1; result = 16'hAAAA;
    @(negedge clk);
    vectors++;
    if ({d_valid, if_valid, stall, d_rdata} !== {3'b101, 16'hAAAA}) begin
      miscompares++;
      $display("FAIL both_data_resp: got %h exp %h", {d_valid, if_valid, stall, d_rdata}, {3'b101, 16'hAAAA});
    end
    d_rd = 0;
    @(negedge clk);
    vectors++;
    if ({d_valid, if_valid, stall, need_to_work} !== 4'b0010) begin
      miscompares++; $display("FAIL both_gap: got %b exp 0010", {d_valid, if_valid, stall, need_to_work});
    end
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, stall, mem_addr} !== {3'b111, 16'h0050}) begin
      miscompares++;
      $display("FAIL both_fetch_issue: got %h exp %h", {need_to_work, mem_rd, stall, mem_addr},
               {3'b111, 16'h0050});
    end
    work_done = 0;
    @(negedge clk);
    work_done = 1; result = 16'h5555;
    @(negedge clk);
    vectors++;
    if ({if_valid, d_valid, stall, if_data, d_rdata} !== {3'b100, 16'h5555, 16'hAAAA}) begin
      miscompares++;
      $display("FAIL both_fetch_resp: got %h exp %h", {if_valid, d_valid, stall, if_data, d_rdata},
               {3'b100, 16'h5555, 16'hAAAA});
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_uart_stat();
    front = 4'd3; tail = 4'd5; d_rd = 1; d_addr = 16'hBF01;
    @(negedge clk);
    vectors++;
    if ({d_valid, need_to_work, mem_rd, stall, d_rdata} !== {4'b1000, 16'h0003}) begin
      miscompares++;
      $display("FAIL stat_nonempty: got %h exp %h", {d_valid, need_to_work, mem_rd, stall, d_rdata},
               {4'b1000, 16'h0003});
    end
    d_rd = 0;
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b0) begin miscompares++; $display("FAIL stat_pulse: got %b exp 0", d_valid); end
    front = 4'd5; d_rd = 1;
    @(negedge clk);
    vectors++;
    if ({d_valid, need_to_work, d_rdata} !== {2'b10, 16'h0001}) begin
      miscompares++;
      $display("FAIL stat_empty: got %h exp %h", {d_valid, need_to_work, d_rdata}, {2'b10, 16'h0001});
    end
    d_rd = 0;
    @(negedge clk);
  endtask

  task automatic test_rx_preempt();
    if_req = 1; if_addr = 16'h0060;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({need_to_work, stall, if_valid} !== 3'b110) begin
        miscompares++;
        $display("FAIL preempt_hold%0d: got %b exp 110", i, {need_to_work, stall, if_valid});
      end
    end
    work_done = 0;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd} !== 2'b01) begin
      miscompares++; $display("FAIL preempt_wait: got %b exp 01", {need_to_work, mem_rd});
    end
    work_done = 1; result = 16'h1357;
    @(negedge clk);
    vectors++;
    if ({if_valid, err, if_data} !== {2'b10, 16'h1357}) begin
      miscompares++;
      $display("FAIL preempt_resp: got %h exp %h", {if_valid, err, if_data}, {2'b10, 16'h1357});
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout_reset();
    d_rd = 1; d_addr = 16'h9002;
    repeat (1023) @(negedge clk);
    vectors++;
    if ({err, need_to_work, d_valid} !== 3'b010) begin
      miscompares++; $display("FAIL timeout_before: got %b exp 010", {err, need_to_work, d_valid});
    end
    @(negedge clk);
    vectors++;
    if ({d_valid, err, need_to_work, d_rdata} !== {3'b110, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL timeout_resp: got %h exp %h", {d_valid, err, need_to_work, d_rdata}, {3'b110, 16'hFFFF});
    end
    d_rd = 0;
    @(negedge clk);
    vectors++;
    if ({d_valid, err, mem_rd} !== 3'b010) begin
      miscompares++; $display("FAIL timeout_sticky: got %b exp 010", {d_valid, err, mem_rd});
    end
    if_req = 1; if_addr = 16'h0070;
    @(negedge clk);
    work_done = 0;
    @(negedge clk);
    vectors++;
    if ({need_to_work, mem_rd, mem_addr} !== {2'b01, 16'h0070}) begin
      miscompares++;
      $display("FAIL midwait: got %h exp %h", {need_to_work, mem_rd, mem_addr}, {2'b01, 16'h0070});
    end
    #2 if_req = 0; rst = 0;
    #1 vectors++;
    if ({need_to_work, mem_rd, mem_wr, mem_addr, mem_value, if_data, d_rdata, if_valid, d_valid, err, stall}
        !== 71'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h exp 0", {need_to_work, mem_rd, mem_wr, mem_addr, mem_value,
               if_data, d_rdata, if_valid, d_valid, err, stall});
    end
    @(negedge clk);
    work_done = 1; result = 16'hBEEF;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({if_valid, d_valid, need_to_work, if_data} !== 19'h0) begin
        miscompares++;
        $display("FAIL no_pulse%0d: got %h exp 0", i, {if_valid, d_valid, need_to_work, if_data});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_both();
    test_uart_stat();
    test_rx_preempt();
    test_timeout_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
